// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - state encoding and pattern constant for the 1011 detector
package seq_det_pkg;

  localparam int ST_W = 3;

  // Pattern being detected, kept here so the state names have a reference.
  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with sync active-low reset and clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - overlapping Moore detector for serial pattern 1011
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             det,
  output logic [ST_W-1:0]  state_o,
  output logic [CNT_W-1:0] match_count
);

  state_t r_state;
  state_t w_next;
  logic   r_det;
  logic   w_inc;

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = din ? S1    : IDLE;
      S1:      w_next = din ? S1    : S10;
      S10:     w_next = din ? S101  : IDLE;
      S101:    w_next = din ? S1011 : S10;
      S1011:   w_next = din ? S1    : S10;
      default: w_next = IDLE;
    endcase
  end

  // det is registered from the same next-state value, so it always equals (r_state == S1011).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_det   <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_det   <= 1'b0;
    end else if (din_valid) begin
      r_state <= w_next;
      r_det   <= (w_next == S1011);
    end
  end

  assign w_inc = din_valid && (w_next == S1011) && (r_state != S1011);

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (w_inc),
    .count (match_count)
  );

  assign det     = r_det;
  assign state_o = r_state;

endmodule
